// File: rtl/store_align_unit.sv
// Store alignment unit: places rs2 data into the byte lanes of a 32-bit write port,
// splitting stores that cross a word boundary into two write beats.
module store_align_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_data,
    input  logic [2:0]            req_funct3,
    output logic                  mem_wvalid,
    input  logic                  mem_wready,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wstrb,
    output logic                  done,
    output logic                  err,
    output logic                  split
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state, state_next;

    logic                  accept;
    logic                  legal;
    logic [3:0]            base_strb;
    logic [31:0]           masked_data;
    logic [63:0]           data_wide;
    logic [7:0]            strb_wide;
    logic                  needs_split;
    logic [ADDR_WIDTH-1:0] addr_beat0;
    logic [ADDR_WIDTH-1:0] addr_beat1;

    logic [ADDR_WIDTH-1:0] b1_addr;
    logic [31:0]           b1_data;
    logic [3:0]            b1_strb;
    logic                  err_q;

    assign accept = req_valid && (state == IDLE);

    // Size decode and lane shift of the incoming request.
    always_comb begin
        legal       = 1'b1;
        base_strb   = 4'b0000;
        masked_data = 32'h0;
        case (req_funct3)
            3'b000: begin
                base_strb   = 4'b0001;
                masked_data = {24'h0, req_data[7:0]};
            end
            3'b001: begin
                base_strb   = 4'b0011;
                masked_data = {16'h0, req_data[15:0]};
            end
            3'b010: begin
                base_strb   = 4'b1111;
                masked_data = req_data;
            end
            default: legal = 1'b0;
        endcase
        data_wide   = {32'h0, masked_data} << {req_addr[1:0], 3'b000};
        strb_wide   = {4'h0, base_strb} << req_addr[1:0];
        needs_split = legal && (strb_wide[7:4] != 4'b0000);
        addr_beat0  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
        addr_beat1  = addr_beat0 + ADDR_WIDTH'(4);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept) state_next = legal ? BEAT0 : RESP;
            BEAT0: if (mem_wready) state_next = split ? BEAT1 : RESP;
            BEAT1: if (mem_wready) state_next = RESP;
            RESP:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Payload registers: beat-0 fields load at acceptance, beat-1 fields on the beat-0 handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_waddr <= '0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'h0;
            b1_addr   <= '0;
            b1_data   <= 32'h0;
            b1_strb   <= 4'h0;
            err_q     <= 1'b0;
            split     <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    split <= 1'b0;
                    if (accept) begin
                        err_q <= !legal;
                        split <= needs_split;
                        if (legal) begin
                            mem_waddr <= addr_beat0;
                            mem_wdata <= data_wide[31:0];
                            mem_wstrb <= strb_wide[3:0];
                            b1_addr   <= addr_beat1;
                            b1_data   <= data_wide[63:32];
                            b1_strb   <= strb_wide[7:4];
                        end
                    end
                end
                BEAT0: begin
                    if (mem_wready && split) begin
                        mem_waddr <= b1_addr;
                        mem_wdata <= b1_data;
                        mem_wstrb <= b1_strb;
                    end
                end
                RESP: begin
                    split <= 1'b0;
                    err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign mem_wvalid = (state == BEAT0) || (state == BEAT1);
    assign done       = (state == RESP);
    assign err        = (state == RESP) && err_q;

endmodule

// File: tb/tb_store_align_unit.sv
// Directed testbench for store_align_unit: hand-computed lane placement, split,
// wrap-around, backpressure, illegal funct3 and mid-operation reset.
module tb_store_align_unit;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_data;
    logic [2:0]    req_funct3;
    logic          mem_wvalid;
    logic          mem_wready;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          done;
    logic          err;
    logic          split;

    int vectors = 0;
    int miscompares = 0;

    store_align_unit #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_funct3 (req_funct3),
        .mem_wvalid (mem_wvalid),
        .mem_wready (mem_wready),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .done       (done),
        .err        (err),
        .split      (split)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for req_ready, presents one request for a single accepting edge.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
        int n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        checkOutput("req_ready_before_accept", req_ready, 1);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_data   = data;
        req_funct3 = f3;
        step();
        req_valid  = 1'b0;
    endtask

    task automatic runStore(input string name, input logic [31:0] addr, input logic [31:0] data,
                            input logic [2:0] f3, input logic exp_split,
                            input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] s0,
                            input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] s1);
        applyStimulus(addr, data, f3);
        checkOutput({name, "_b0_wvalid"}, mem_wvalid, 1);
        checkOutput({name, "_b0_waddr"}, mem_waddr, a0);
        checkOutput({name, "_b0_wdata"}, mem_wdata, d0);
        checkOutput({name, "_b0_wstrb"}, mem_wstrb, s0);
        checkOutput({name, "_b0_split"}, split, exp_split);
        checkOutput({name, "_b0_done"}, done, 0);
        checkOutput({name, "_b0_ready"}, req_ready, 0);
        step();
        if (exp_split) begin
            checkOutput({name, "_b1_wvalid"}, mem_wvalid, 1);
            checkOutput({name, "_b1_waddr"}, mem_waddr, a1);
            checkOutput({name, "_b1_wdata"}, mem_wdata, d1);
            checkOutput({name, "_b1_wstrb"}, mem_wstrb, s1);
            checkOutput({name, "_b1_split"}, split, 1);
            checkOutput({name, "_b1_done"}, done, 0);
            step();
        end
        checkOutput({name, "_resp_done"}, done, 1);
        checkOutput({name, "_resp_err"}, err, 0);
        checkOutput({name, "_resp_wvalid"}, mem_wvalid, 0);
        checkOutput({name, "_resp_split"}, split, exp_split);
        step();
        checkOutput({name, "_idle_ready"}, req_ready, 1);
        checkOutput({name, "_idle_done"}, done, 0);
        checkOutput({name, "_idle_split"}, split, 0);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_data   = 32'h0;
        req_funct3 = 3'b000;
        mem_wready = 1'b1;
        step();
        step();
        checkOutput("rst_ready", req_ready, 1);
        checkOutput("rst_wvalid", mem_wvalid, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_split", split, 0);
        checkOutput("rst_waddr", mem_waddr, 0);
        checkOutput("rst_wdata", mem_wdata, 0);
        checkOutput("rst_wstrb", mem_wstrb, 0);
        reset = 1'b0;
        step();

        runStore("sb_1003", 32'h1003, 32'hAABBCCDD, 3'b000, 0,
                 32'h1000, 32'hDD000000, 4'b1000, 32'h0, 32'h0, 4'h0);
        runStore("sh_2002", 32'h2002, 32'h12345678, 3'b001, 0,
                 32'h2000, 32'h56780000, 4'b1100, 32'h0, 32'h0, 4'h0);
        runStore("sw_2000", 32'h2000, 32'hCAFEF00D, 3'b010, 0,
                 32'h2000, 32'hCAFEF00D, 4'b1111, 32'h0, 32'h0, 4'h0);
        runStore("sb_0000", 32'h0000, 32'h123456FF, 3'b000, 0,
                 32'h0000, 32'h000000FF, 4'b0001, 32'h0, 32'h0, 4'h0);
        runStore("sh_0001", 32'h0001, 32'hABCD1234, 3'b001, 0,
                 32'h0000, 32'h00123400, 4'b0110, 32'h0, 32'h0, 4'h0);
        runStore("sw_3001", 32'h3001, 32'h11223344, 3'b010, 1,
                 32'h3000, 32'h22334400, 4'b1110, 32'h3004, 32'h00000011, 4'b0001);
        runStore("sh_wrap", 32'hFFFFFFFF, 32'h0000BEEF, 3'b001, 1,
                 32'hFFFFFFFC, 32'hEF000000, 4'b1000, 32'h00000000, 32'h000000BE, 4'b0001);

        // Backpressure: beat must hold stable for five stalled cycles.
        mem_wready = 1'b0;
        applyStimulus(32'h10, 32'h5A5AA5A5, 3'b010);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_wvalid", mem_wvalid, 1);
            checkOutput("bp_waddr", mem_waddr, 32'h10);
            checkOutput("bp_wdata", mem_wdata, 32'h5A5AA5A5);
            checkOutput("bp_wstrb", mem_wstrb, 4'b1111);
            checkOutput("bp_done", done, 0);
            if (i < 4) step();
        end
        mem_wready = 1'b1;
        step();
        checkOutput("bp_resp_done", done, 1);
        checkOutput("bp_resp_wvalid", mem_wvalid, 0);
        step();
        checkOutput("bp_idle_ready", req_ready, 1);

        // Illegal funct3 goes straight to the response with err.
        applyStimulus(32'h40, 32'hDEADBEEF, 3'b011);
        checkOutput("ill_done", done, 1);
        checkOutput("ill_err", err, 1);
        checkOutput("ill_wvalid", mem_wvalid, 0);
        checkOutput("ill_split", split, 0);
        step();
        checkOutput("ill_idle_done", done, 0);
        checkOutput("ill_idle_err", err, 0);
        checkOutput("ill_idle_ready", req_ready, 1);

        // Reset during the second beat of a split store abandons it.
        applyStimulus(32'h3001, 32'h11223344, 3'b010);
        checkOutput("rb_b0_wvalid", mem_wvalid, 1);
        step();
        checkOutput("rb_b1_wvalid", mem_wvalid, 1);
        checkOutput("rb_b1_wstrb", mem_wstrb, 4'b0001);
        reset = 1'b1;
        step();
        checkOutput("rb_rst_wvalid", mem_wvalid, 0);
        checkOutput("rb_rst_done", done, 0);
        checkOutput("rb_rst_split", split, 0);
        reset = 1'b0;
        step();
        checkOutput("rb_post_done", done, 0);
        checkOutput("rb_post_ready", req_ready, 1);
        checkOutput("rb_post_wvalid", mem_wvalid, 0);
        runStore("rb_sb", 32'h1003, 32'hAABBCCDD, 3'b000, 0,
                 32'h1000, 32'hDD000000, 4'b1000, 32'h0, 32'h0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
